// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants for the register write arbiter: data width and FSM encodings.
package reg_wr_arbiter_pkg;

    localparam int WORDSIZE = 32;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_LOAD = 2'd1;
    localparam logic [1:0] ARB_ACK  = 2'd2;

endpackage

// File: rtl/reg_wr_arbiter_d_ff_en.sv
// Enabled WORDSIZE-bit storage register with synchronous active-high clear.
module d_ff_en
    import reg_wr_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [WORDSIZE-1:0] d,
    output logic [WORDSIZE-1:0] q
);

    logic [WORDSIZE-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr)
            r_q <= '0;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one d_ff_en register among N_REQ writers.
// IDLE picks a winner, LOAD writes its slice, ACK pulses the ack and rotates priority.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORDSIZE-1:0] wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic [WORDSIZE-1:0]       q
);

    logic [1:0]          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_sel;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_ack;

    logic                w_any;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                w_en;
    logic [WORDSIZE-1:0] w_d;

    // Scan from the far end back toward r_ptr so the nearest set bit wins last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % N_REQ]) begin
                w_any = 1'b1;
                w_win = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_ptr_next = (r_sel == PTR_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
    assign w_en       = (r_state == ARB_LOAD);
    assign w_d        = wdata[r_sel*WORDSIZE +: WORDSIZE];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= ARB_LOAD;
                        r_sel   <= w_win;
                        r_gnt   <= N_REQ'(1) << w_win;
                    end
                end
                ARB_LOAD: begin
                    // The write is committed once granted, even if req drops here.
                    r_state <= ARB_ACK;
                    r_gnt   <= '0;
                    r_ack   <= N_REQ'(1) << r_sel;
                end
                ARB_ACK: begin
                    r_state <= ARB_IDLE;
                    r_ack   <= '0;
                    r_ptr   <= w_ptr_next;
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_gnt   <= '0;
                    r_ack   <= '0;
                end
            endcase
        end
    end

    d_ff_en u_store (
        .clk (clk),
        .clr (clr),
        .en  (w_en),
        .d   (w_d),
        .q   (q)
    );

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations per scenario.
module tb_reg_wr_arbiter;
    import reg_wr_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = WORDSIZE;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   wdata = '0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic             busy;
    logic [W-1:0]     q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int ack_idx[$];
    int ack_cyc[$];

    reg_wr_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, three cycles each.
    int           m_left = 0;
    int           m_ptr  = 0;
    int           m_win  = 0;
    logic [N-1:0] e_gnt  = '0;
    logic [N-1:0] e_ack  = '0;
    logic [W-1:0] e_q    = '0;

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_left = 0; m_ptr = 0; e_gnt = '0; e_ack = '0; e_q = '0;
        end else if (m_left == 0) begin
            if (req != '0) begin
                m_win = pick(req, m_ptr);
                e_gnt = '0;
                e_gnt[m_win] = 1'b1;
                m_left = 2;
            end
        end else if (m_left == 2) begin
            e_q   = wdata[m_win*W +: W];
            e_gnt = '0;
            e_ack = '0;
            e_ack[m_win] = 1'b1;
            m_left = 1;
        end else begin
            e_ack  = '0;
            m_ptr  = (m_win + 1) % N;
            m_left = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("ack", 32'(ack), 32'(e_ack));
            check("busy", 32'(busy), 32'(m_left != 0));
            check("q", q, e_q);
            for (int i = 0; i < N; i++)
                if (ack[i]) begin
                    ack_idx.push_back(i);
                    ack_cyc.push_back(cyc);
                end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic serve(input logic [N-1:0] mask, output int who);
        req = mask;
        who = -1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (ack != '0) begin
                for (int i = 0; i < N; i++) if (ack[i]) who = i;
                req = '0;
                break;
            end
        end
        if (who < 0) check("serve_timeout", 32'(ack), 32'(mask));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset
        clr = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", q, 32'd0);

        // Single request from requester 2
        wdata[2*W +: W] = 32'hDEADBEEF;
        req = 4'b0100;
        tick();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_q", q, 32'hDEADBEEF);
        check("t1_ack", 32'(ack), 32'h4);
        req = '0;
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // All requesting: order 0,1,2,3,0 from a fresh pointer
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        ack_idx.delete();
        ack_cyc.delete();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 32'h1111_1111 * (i + 1);
        req = '1;
        n = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
            tick();
            if (ack != '0) begin
                for (int i = 0; i < N; i++)
                    if (ack[i]) check("t2_q_lit", q, 32'h1111_1111 * (i + 1));
                n++;
            end
        end
        req = '0;
        check("t2_nacks", 32'(n), 32'd5);
        repeat (2) tick();
        check("t2_qsize", 32'(ack_idx.size()), 32'd5);
        if (ack_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t2_order", 32'(ack_idx[k]), 32'(exp_order[k]));
            for (int k = 1; k < 5; k++) check("t2_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        end

        // Pointer wrap: after serving 3, requester 0 beats 3
        serve(4'b1000, w);
        check("t3_prev", 32'(w), 32'd3);
        req = 4'b1001;
        tick();
        check("t3_gnt", 32'(gnt), 32'h1);
        tick();
        check("t3_ack", 32'(ack), 32'h1);
        req = '0;
        tick();

        // req[1] drops during LOAD; the write still completes
        wdata[1*W +: W] = 32'hCAFE_0001;
        req = 4'b0010;
        tick();
        check("t4_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("t4_ack", 32'(ack), 32'h2);
        check("t4_q", q, 32'hCAFE_0001);
        tick();
        check("t4_idle", 32'(busy), 32'd0);

        // clr in LOAD abandons the write and resets the pointer
        wdata[1*W +: W] = 32'h5555_AAAA;
        req = 4'b0010;
        tick();
        clr = 1'b1;
        req = '0;
        tick();
        check("t5_q", q, 32'd0);
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        clr = 1'b0;
        tick();
        check("t5_noack", 32'(ack), 32'd0);
        wdata[1*W +: W] = 32'h0000_1234;
        wdata[2*W +: W] = 32'h0000_5678;
        req = 4'b0110;
        tick();
        check("t5_ptr0_gnt", 32'(gnt), 32'h2);
        tick();
        check("t5_ack2", 32'(ack), 32'h2);
        check("t5_q2", q, 32'h0000_1234);
        req = '0;
        tick();

        // Idle hold after a write of 0xA5
        wdata[0*W +: W] = 32'h0000_00A5;
        serve(4'b0001, w);
        check("t6_who", 32'(w), 32'd0);
        repeat (20) begin
            tick();
            check("t6_q", q, 32'h0000_00A5);
            check("t6_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
